// File: rtl/mainm_arbiter_if.sv
// ---------------------------------------------------------------------------
// mainm_arbiter_if
//   One memory-style request bus: address, write data, write request, read
//   request, read data and completion pulse. Used for both master ports of
//   the arbiter and for the link to the memory controller.
//
//   Handshake: the master raises rd or we with a/d stable and holds all of
//   them until it samples ready high; ready is a one-cycle pulse that
//   qualifies spo; the master drops the request in the cycle after ready.
//   rd and we raised together denote a write.
//
//   Signals:
//     a     [31:0]  address                 (master -> slave)
//     d     [31:0]  write data              (master -> slave)
//     we            write request           (master -> slave)
//     rd            read request            (master -> slave)
//     spo   [31:0]  read data               (slave -> master)
//     ready         completion pulse        (slave -> master)
// ---------------------------------------------------------------------------
interface mainm_arbiter_if;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  modport master (output a, d, we, rd, input spo, ready);
  modport slave  (input a, d, we, rd, output spo, ready);
endinterface

// File: rtl/mainm_arbiter.sv
// ---------------------------------------------------------------------------
// mainm_arbiter
//   Shares the single main-memory (PSRAM) controller between two masters.
//   Port 0 is the CPU path, port 1 a secondary master (serial loader, DMA).
//   Requests are registered onto the memory bus one cycle after they are
//   raised; a mandatory IDLE cycle follows every completion. A watchdog
//   aborts a transaction that waits too long for ready_mem.
//
//   Parameters:
//     FIXED_PRIO  0: round-robin, 1: port 0 wins simultaneous requests
//     TIMEOUT     cycles a granted transaction may wait; 0 disables
//     ERR_DATA    read data returned to the aborted port on a timeout
//
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     p0, p1      master ports (slave side of the bus)
//     mem         memory controller link (master side of the bus)
//     grant[1:0]  one-hot owner of the memory, 00 when idle
//     timeout     pulse in the cycle a transaction is aborted
//     state_dbg   current FSM state (IDLE=0, BUSY0=1, BUSY1=2)
// ---------------------------------------------------------------------------
module mainm_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 65535,
  parameter logic [31:0] ERR_DATA   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  mainm_arbiter_if.slave    p0,
  mainm_arbiter_if.slave    p1,
  mainm_arbiter_if.master   mem,
  output logic [1:0]        grant,
  output logic              timeout,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  // The counter only has to reach TIMEOUT-1.
  localparam int unsigned CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned LIMIT   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LIMIT_C = LIMIT[CW-1:0];
  localparam bit          WD_EN   = (TIMEOUT != 0);

  state_t        state;
  logic          last_grant;   // index of the port granted most recently
  logic [CW-1:0] wd_cnt;

  logic req0;
  logic req1;
  logic pick1;
  logic busy;
  logic expire;
  logic done;

  always_comb begin
    req0   = p0.rd | p0.we;
    req1   = p1.rd | p1.we;
    // Port 1 wins when alone, or on a tie in round-robin mode when port 0
    // was served last.
    pick1  = req1 & (~req0 | ((FIXED_PRIO == 0) && !last_grant));
    busy   = (state != IDLE);
    // A completion in the limit cycle wins over the abort.
    expire = WD_EN && busy && (wd_cnt == LIMIT_C) && !mem.ready;
    done   = busy & (mem.ready | expire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem.a      <= '0;
      mem.d      <= '0;
      mem.we     <= 1'b0;
      mem.rd     <= 1'b0;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (req0 | req1) begin
            if (pick1) begin
              mem.a      <= p1.a;
              mem.d      <= p1.d;
              mem.we     <= p1.we;
              mem.rd     <= p1.rd & ~p1.we;
              grant      <= 2'b10;
              last_grant <= 1'b1;
              state      <= BUSY1;
            end else begin
              mem.a      <= p0.a;
              mem.d      <= p0.d;
              mem.we     <= p0.we;
              mem.rd     <= p0.rd & ~p0.we;
              grant      <= 2'b01;
              last_grant <= 1'b0;
              state      <= BUSY0;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (done) begin
            // Going through IDLE keeps rd/we low for a cycle and stops a
            // still-high request from being re-issued.
            mem.a  <= '0;
            mem.d  <= '0;
            mem.we <= 1'b0;
            mem.rd <= 1'b0;
            grant  <= 2'b00;
            wd_cnt <= '0;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          mem.a  <= '0;
          mem.d  <= '0;
          mem.we <= 1'b0;
          mem.rd <= 1'b0;
          grant  <= 2'b00;
          wd_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Completion path is combinational from the memory controller; the
  // non-granted port always sees zeros.
  assign p0.ready  = (state == BUSY0) & (mem.ready | expire);
  assign p0.spo    = (state == BUSY0) ? (expire ? ERR_DATA : mem.spo) : 32'd0;
  assign p1.ready  = (state == BUSY1) & (mem.ready | expire);
  assign p1.spo    = (state == BUSY1) ? (expire ? ERR_DATA : mem.spo) : 32'd0;
  assign timeout   = expire;
  assign state_dbg = state;

endmodule

// File: tb/tb_mainm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mainm_arbiter
//   Two arbiter instances, both TIMEOUT=16: index 0 round-robin, index 1
//   fixed priority. Each has its own memory responder that returns
//   ready_mem mem_lat cycles after rd_mem/we_mem rises (or never).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mainm_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] a0_s [2];
  logic [31:0] d0_s [2];
  logic [31:0] a1_s [2];
  logic [31:0] d1_s [2];
  logic        rd0_s [2];
  logic        we0_s [2];
  logic        rd1_s [2];
  logic        we1_s [2];
  int          mem_lat [2];
  bit          mem_never [2];
  logic [31:0] mem_data [2];

  logic [31:0] spo0_o [2];
  logic [31:0] spo1_o [2];
  logic [31:0] a_mem_o [2];
  logic [31:0] d_mem_o [2];
  logic        ready0_o [2];
  logic        ready1_o [2];
  logic        rd_mem_o [2];
  logic        we_mem_o [2];
  logic        to_o [2];
  logic [1:0]  grant_o [2];
  logic [1:0]  state_o [2];

  logic [1:0]  seq_q [$];

  for (genvar g = 0; g < 2; g++) begin : dut_g
    mainm_arbiter_if p0_if ();
    mainm_arbiter_if p1_if ();
    mainm_arbiter_if mem_if ();
    logic        ready_mem_r = 1'b0;
    logic [31:0] spo_mem_r = 32'd0;
    int          rsp_cnt = 0;

    assign p0_if.a  = a0_s[g];
    assign p0_if.d  = d0_s[g];
    assign p0_if.rd = rd0_s[g];
    assign p0_if.we = we0_s[g];
    assign p1_if.a  = a1_s[g];
    assign p1_if.d  = d1_s[g];
    assign p1_if.rd = rd1_s[g];
    assign p1_if.we = we1_s[g];
    assign mem_if.spo   = spo_mem_r;
    assign mem_if.ready = ready_mem_r;
    assign spo0_o[g]   = p0_if.spo;
    assign spo1_o[g]   = p1_if.spo;
    assign ready0_o[g] = p0_if.ready;
    assign ready1_o[g] = p1_if.ready;
    assign a_mem_o[g]  = mem_if.a;
    assign d_mem_o[g]  = mem_if.d;
    assign rd_mem_o[g] = mem_if.rd;
    assign we_mem_o[g] = mem_if.we;

    mainm_arbiter #(
      .FIXED_PRIO(g),
      .TIMEOUT   (16),
      .ERR_DATA  (32'hFFFF_FFFF)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .p0       (p0_if),
      .p1       (p1_if),
      .mem      (mem_if),
      .grant    (grant_o[g]),
      .timeout  (to_o[g]),
      .state_dbg(state_o[g])
    );

    // Memory model: ready_mem mem_lat cycles after the request appears.
    always begin
      @(posedge clk);
      #1;
      ready_mem_r = 1'b0;
      spo_mem_r   = 32'd0;
      if ((mem_if.rd || mem_if.we) && !mem_never[g]) begin
        if (rsp_cnt == mem_lat[g]) begin
          ready_mem_r = 1'b1;
          spo_mem_r   = mem_data[g];
          rsp_cnt     = 0;
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      a0_s[d] = '0; d0_s[d] = '0; a1_s[d] = '0; d1_s[d] = '0;
      rd0_s[d] = 1'b0; we0_s[d] = 1'b0; rd1_s[d] = 1'b0; we1_s[d] = 1'b0;
      mem_lat[d] = 1; mem_never[d] = 1'b0; mem_data[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (grant_o[d] !== 2'b00) begin errors++; $display("FAIL reset_grant dut%0d got %b want 00", d, grant_o[d]); end
      checks++; if (rd_mem_o[d] !== 1'b0 || we_mem_o[d] !== 1'b0) begin errors++; $display("FAIL reset_req dut%0d got rd=%b we=%b want 0 0", d, rd_mem_o[d], we_mem_o[d]); end
      checks++; if (a_mem_o[d] !== 32'd0 || d_mem_o[d] !== 32'd0) begin errors++; $display("FAIL reset_bus dut%0d got a=%h d=%h want 0 0", d, a_mem_o[d], d_mem_o[d]); end
      checks++; if (to_o[d] !== 1'b0) begin errors++; $display("FAIL reset_timeout dut%0d got %b want 0", d, to_o[d]); end
      checks++; if (state_o[d] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d want 0", d, state_o[d]); end
      checks++; if (ready0_o[d] !== 1'b0 || ready1_o[d] !== 1'b0 || spo0_o[d] !== 32'd0 || spo1_o[d] !== 32'd0) begin errors++; $display("FAIL reset_ports dut%0d got r0=%b r1=%b s0=%h s1=%h want zeros", d, ready0_o[d], ready1_o[d], spo0_o[d], spo1_o[d]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [1:0] eg [6];
    logic       erd [6];
    logic       er0 [6];
    eg  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    erd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    er0 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mem_lat[0] = 3; mem_data[0] = 32'hCAFE_BABE;
    @(negedge clk);
    checks++; if (rd_mem_o[0] !== 1'b0) begin errors++; $display("FAIL single_pre_rd got %b want 0", rd_mem_o[0]); end
    a0_s[0] = 32'h2000_0040; rd0_s[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (grant_o[0] !== eg[c-1]) begin errors++; $display("FAIL single_grant c%0d got %b want %b", c, grant_o[0], eg[c-1]); end
      checks++; if (rd_mem_o[0] !== erd[c-1]) begin errors++; $display("FAIL single_rd_mem c%0d got %b want %b", c, rd_mem_o[0], erd[c-1]); end
      checks++; if (ready0_o[0] !== er0[c-1]) begin errors++; $display("FAIL single_ready0 c%0d got %b want %b", c, ready0_o[0], er0[c-1]); end
      checks++; if (ready1_o[0] !== 1'b0 || spo1_o[0] !== 32'd0) begin errors++; $display("FAIL single_port1 c%0d got r1=%b s1=%h want 0 0", c, ready1_o[0], spo1_o[0]); end
      if (c == 1) begin
        checks++; if (a_mem_o[0] !== 32'h2000_0040 || we_mem_o[0] !== 1'b0) begin errors++; $display("FAIL single_addr got a=%h we=%b want 20000040 0", a_mem_o[0], we_mem_o[0]); end
      end
      if (c == 4) begin
        checks++; if (spo0_o[0] !== 32'hCAFE_BABE) begin errors++; $display("FAIL single_data got %h want cafebabe", spo0_o[0]); end
      end
      if (c == 5) rd0_s[0] = 1'b0;
    end
  endtask

  // Port 0 reads and port 1 writes, both held until 4 completions each.
  task automatic run_pair(input int d);
    int rem0 = 4;
    int rem1 = 4;
    bit drop0 = 1'b0;
    bit drop1 = 1'b0;
    int after = 0;
    int cyc = 0;
    logic [1:0] prev_g = 2'b00;
    seq_q.delete();
    mem_lat[d] = 1; mem_data[d] = 32'h0BAD_F00D;
    a0_s[d] = 32'h0000_1000; rd0_s[d] = 1'b1;
    a1_s[d] = 32'h0000_2000; d1_s[d] = 32'h1234_5678; we1_s[d] = 1'b1;
    while ((rem0 > 0 || rem1 > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (drop0) begin rd0_s[d] = 1'b0; drop0 = 1'b0; end
      if (drop1) begin we1_s[d] = 1'b0; drop1 = 1'b0; end
      if (grant_o[d] != 2'b00 && prev_g == 2'b00) begin
        seq_q.push_back(grant_o[d]);
        if (grant_o[d] == 2'b10) begin
          checks++; if (we_mem_o[d] !== 1'b1 || rd_mem_o[d] !== 1'b0 || d_mem_o[d] !== 32'h1234_5678) begin errors++; $display("FAIL pair_write dut%0d got we=%b rd=%b d=%h want 1 0 12345678", d, we_mem_o[d], rd_mem_o[d], d_mem_o[d]); end
        end else begin
          checks++; if (rd_mem_o[d] !== 1'b1 || we_mem_o[d] !== 1'b0 || a_mem_o[d] !== 32'h0000_1000) begin errors++; $display("FAIL pair_read dut%0d got rd=%b we=%b a=%h want 1 0 00001000", d, rd_mem_o[d], we_mem_o[d], a_mem_o[d]); end
        end
      end
      if (after == 1) begin
        checks++; if (grant_o[d] !== 2'b00 || rd_mem_o[d] !== 1'b0 || we_mem_o[d] !== 1'b0) begin errors++; $display("FAIL pair_idle dut%0d got g=%b rd=%b we=%b want 00 0 0", d, grant_o[d], rd_mem_o[d], we_mem_o[d]); end
      end
      if (after == 2) begin
        checks++; if (grant_o[d] === 2'b00) begin errors++; $display("FAIL pair_regrant dut%0d got 00 want a grant", d); end
      end
      if (after > 0) after++;
      if (ready0_o[d] === 1'b1) begin
        checks++; if (rem0 == 0) begin errors++; $display("FAIL pair_extra_ready0 dut%0d got pulse want none", d); end
        else begin rem0--; if (rem0 == 0) drop0 = 1'b1; end
        after = 1;
      end
      if (ready1_o[d] === 1'b1) begin
        checks++; if (rem1 == 0) begin errors++; $display("FAIL pair_extra_ready1 dut%0d got pulse want none", d); end
        else begin rem1--; if (rem1 == 0) drop1 = 1'b1; end
        after = 1;
      end
      prev_g = grant_o[d];
    end
    checks++; if (cyc >= 200) begin errors++; $display("FAIL pair_budget dut%0d got rem0=%0d rem1=%0d want 0 0", d, rem0, rem1); end
    @(negedge clk);
    rd0_s[d] = 1'b0; we1_s[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    run_pair(0);
    checks++; if (seq_q.size() != 8) begin errors++; $display("FAIL rr_count got %0d want 8", seq_q.size()); end
    for (int i = 0; i < seq_q.size() && i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (seq_q[i] !== exp_g) begin errors++; $display("FAIL rr_order[%0d] got %b want %b", i, seq_q[i], exp_g); end
    end
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_g;
    run_pair(1);
    checks++; if (seq_q.size() != 8) begin errors++; $display("FAIL fp_count got %0d want 8", seq_q.size()); end
    for (int i = 0; i < seq_q.size() && i < 8; i++) begin
      exp_g = (i < 4) ? 2'b01 : 2'b10;
      checks++; if (seq_q[i] !== exp_g) begin errors++; $display("FAIL fp_order[%0d] got %b want %b", i, seq_q[i], exp_g); end
    end
  endtask

  task automatic test_rd_we_together();
    mem_lat[0] = 0; mem_data[0] = 32'd0;
    a1_s[0] = 32'h0000_0100; d1_s[0] = 32'hA5A5_5A5A; rd1_s[0] = 1'b1; we1_s[0] = 1'b1;
    @(negedge clk);
    checks++; if (we_mem_o[0] !== 1'b1 || rd_mem_o[0] !== 1'b0) begin errors++; $display("FAIL rdwe_req got we=%b rd=%b want 1 0", we_mem_o[0], rd_mem_o[0]); end
    checks++; if (d_mem_o[0] !== 32'hA5A5_5A5A || a_mem_o[0] !== 32'h0000_0100) begin errors++; $display("FAIL rdwe_bus got d=%h a=%h want a5a55a5a 00000100", d_mem_o[0], a_mem_o[0]); end
    checks++; if (grant_o[0] !== 2'b10 || ready1_o[0] !== 1'b1) begin errors++; $display("FAIL rdwe_done got g=%b r1=%b want 10 1", grant_o[0], ready1_o[0]); end
    @(negedge clk);
    rd1_s[0] = 1'b0; we1_s[0] = 1'b0;
    checks++; if (grant_o[0] !== 2'b00) begin errors++; $display("FAIL rdwe_idle got %b want 00", grant_o[0]); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic ex;
    mem_never[0] = 1'b1;
    a0_s[0] = 32'h3000_0000; rd0_s[0] = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      ex = (c == 16);
      checks++; if (ready0_o[0] !== ex || to_o[0] !== ex) begin errors++; $display("FAIL to_pulse c%0d got r0=%b to=%b want %b %b", c, ready0_o[0], to_o[0], ex, ex); end
      checks++; if (grant_o[0] !== ((c <= 16) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL to_grant c%0d got %b", c, grant_o[0]); end
      if (c == 16) begin
        checks++; if (spo0_o[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_err_data got %h want ffffffff", spo0_o[0]); end
      end
      if (c == 17) rd0_s[0] = 1'b0;
    end
    mem_never[0] = 1'b0; mem_lat[0] = 2; mem_data[0] = 32'h1111_2222;
    @(negedge clk);
    a0_s[0] = 32'h3000_0004; rd0_s[0] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (ready0_o[0] !== (c == 3) || to_o[0] !== 1'b0) begin errors++; $display("FAIL to_next c%0d got r0=%b to=%b want %b 0", c, ready0_o[0], to_o[0], (c == 3)); end
      if (c == 3) begin
        checks++; if (spo0_o[0] !== 32'h1111_2222) begin errors++; $display("FAIL to_next_data got %h want 11112222", spo0_o[0]); end
      end
      if (c == 4) rd0_s[0] = 1'b0;
    end
  endtask

  task automatic test_timeout_race();
    mem_lat[0] = 15; mem_data[0] = 32'h5555_AAAA;
    @(negedge clk);
    a0_s[0] = 32'h3000_0008; rd0_s[0] = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      checks++; if (ready0_o[0] !== (c == 16) || to_o[0] !== 1'b0) begin errors++; $display("FAIL race_pulse c%0d got r0=%b to=%b want %b 0", c, ready0_o[0], to_o[0], (c == 16)); end
      if (c == 16) begin
        checks++; if (spo0_o[0] !== 32'h5555_AAAA) begin errors++; $display("FAIL race_data got %h want 5555aaaa", spo0_o[0]); end
      end
      if (c == 17) begin
        checks++; if (grant_o[0] !== 2'b00) begin errors++; $display("FAIL race_idle got %b want 00", grant_o[0]); end
        rd0_s[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    mem_lat[0] = 10;
    @(negedge clk);
    a1_s[0] = 32'h4000_0000; rd1_s[0] = 1'b1;
    @(negedge clk);
    checks++; if (grant_o[0] !== 2'b10) begin errors++; $display("FAIL rmid_grant got %b want 10", grant_o[0]); end
    @(negedge clk);
    checks++; if (state_o[0] !== 2'd2 || ready1_o[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy got st=%0d r1=%b want 2 0", state_o[0], ready1_o[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rd_mem_o[0] !== 1'b0 || grant_o[0] !== 2'b00 || ready1_o[0] !== 1'b0) begin errors++; $display("FAIL rmid_drop got rd=%b g=%b r1=%b want 0 00 0", rd_mem_o[0], grant_o[0], ready1_o[0]); end
    mem_lat[0] = 1; mem_data[0] = 32'h7777_0000;
    a0_s[0] = 32'h5000_0000; rd0_s[0] = 1'b1;
    @(negedge clk);
    checks++; if (grant_o[0] !== 2'b01) begin errors++; $display("FAIL rmid_first got %b want 01", grant_o[0]); end
    rd1_s[0] = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ready0_o[0] === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL rmid_complete got no ready0 want pulse"); end
    @(negedge clk);
    rd0_s[0] = 1'b0;
    checks++; if (grant_o[0] !== 2'b00) begin errors++; $display("FAIL rmid_idle got %b want 00", grant_o[0]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_rd_we_together();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end
endmodule
